apu_result_queue: RTL and testbench
===================================

Name: apu_result_queue

Overview:
Parametrised successor to the accelerator's combinational APU result mux. Selects a scalar result (new VL, vtype, or any indexed element of vs2) and formats it to ELEN with sign/zero extension. Queues up to DEPTH results and returns them to the core in order over apu_rvalid/apu_result. Sits between vector_decoder/vector_csrs/vector_registers and the core's APU response port; backpressures the decoder via full.

Parameters:
VLEN, 128, vector register width in bits (power of 2, >= 32)
ELEN, 32, result width returned to core
DEPTH, 4, queue entries (power of 2, >= 2)
IDX_W, $clog2(VLEN/8), element index width (max elements at 8b SEW)

Ports:
clk  in  1  clock
n_reset  in  1  synchronous reset, active-high (1 = reset)
res_valid_i  in  1  decoder requests enqueue of one result this cycle
res_src_i  in  apu_result_src_t  VL, VTYPE, VS2_ELEM
res_signed_i  in  1  1 = sign-extend element, 0 = zero-extend
elem_idx_i  in  IDX_W  element index into vs2 for VS2_ELEM
vl_next_i  in  5  next VL, combinational from CSRs
vtype_i  in  5  current {vlmul, vsew, ...} vtype field
vsew_i  in  2  element width: 0 = 8b, 1 = 16b, 2 = 32b, 3 = reserved
vs2_data_i  in  VLEN  vs2 read data
sat_flag_i  in  1  saturation occurred (used only with flags feature)
core_ready_i  in  1  core accepts result this cycle
apu_rvalid_o  out  1  head entry valid
apu_result_o  out  ELEN  head entry data
apu_flags_o  out  5  head entry flags
full_o  out  1  no free entry; decoder must withhold apu_gnt
count_o  out  $clog2(DEPTH)+1  occupied entries
overflow_o  out  1  sticky: push attempted while full without pop

Behaviour:
- Reset (n_reset = 1 at clk edge): pointers, count_o = 0, apu_rvalid_o = 0, apu_result_o = 0, apu_flags_o = 0, full_o = 0, overflow_o = 0. Reset mid-operation discards all entries.
- Formatting is combinational at enqueue; operands are sampled on the push edge.
  - VL: zero-extend vl_next_i.
  - VTYPE: zero-extend vtype_i.
  - VS2_ELEM: take element elem_idx_i of width 8 << vsew_i from vs2_data_i; extend per res_signed_i.
- Out-of-range index (elem_idx_i >= VLEN >> (3 + vsew_i)) or vsew_i = 3: data = 0; flags[0] = 1 (invalid) with the flags feature.
- Push = res_valid_i & (~full_o | pop). Pop = apu_rvalid_o & core_ready_i.
- Latency: result pushed at edge N is visible on apu_rvalid_o/apu_result_o after edge N (registered). No combinational bypass.
- Outputs present the head entry. apu_rvalid_o = (count_o != 0). apu_result_o holds stable while valid and not popped.
- Simultaneous push and pop: allowed at any occupancy, including full; count unchanged.
- Push when full without pop: entry dropped, state unchanged, overflow_o set until reset.
- Pop when empty: impossible (apu_rvalid_o = 0).
- Pointers wrap modulo DEPTH.
- full_o = (count_o == DEPTH), registered.

Optional Feature:
APU_RESULT_FLAGS_EN
- Defined: each entry stores 5 flags, with flags[0] = invalid index and flags[1] = sat_flag_i sampled at push. apu_flags_o shows the head entry's flags.
- Undefined: no flag storage; apu_flags_o tied 0.

Decomposition:
- accelerator_pkg gains:
  - apu_result_src_t extended with VTYPE and VS2_ELEM
  - APU_FLAG_INVALID_IDX = 0 and APU_FLAG_SAT = 1 constants
- Sub-module sync_fifo (WIDTH, DEPTH) holds storage and pointers.
- Formatting and extension stay in apu_result_queue.

Test Plan:
- Reset, then push VL with vl_next_i = 16 -> next cycle apu_rvalid_o = 1, apu_result_o = 0x00000010; core_ready_i = 1 pops; count_o back to 0.
- vsew_i = 0, vs2 byte 3 = 0x85, idx 3: signed push -> 0xFFFFFF85; unsigned push -> 0x00000085; order preserved.
- vsew_i = 1, idx 8 (out of range for 128b) -> result 0; flags = 5'b00001 with APU_RESULT_FLAGS_EN, 0 without.
- core_ready_i = 0, push 5 results (DEPTH = 4) -> full_o = 1 after 4, 5th dropped, overflow_o = 1; drain returns the first 4 in order.
- At full, push and pop in the same cycle -> count_o stays 4, new entry appears last; overflow_o stays 0.
- Assert n_reset with 3 entries queued -> next cycle apu_rvalid_o = 0, count_o = 0, full_o = 0.

Source files
------------

// File: rtl/apu_result_queue_pkg.sv
// Shared types and constants for the APU result queue.
// The flag constants are used when APU_RESULT_FLAGS_EN is defined.
package apu_result_queue_pkg;

  typedef enum logic [1:0] {
    APU_SRC_VL       = 2'd0,
    APU_SRC_VTYPE    = 2'd1,
    APU_SRC_VS2_ELEM = 2'd2
  } apu_result_src_t;

  localparam int APU_FLAGS_W          = 5;
  localparam int APU_FLAG_INVALID_IDX = 0;
  localparam int APU_FLAG_SAT         = 1;

endpackage

// File: rtl/apu_result_queue_if.sv
// Response channel from the result queue to the core's APU port.
interface apu_result_queue_if #(
  parameter int ELEN = 32
);
  logic            apu_rvalid_o;
  logic [ELEN-1:0] apu_result_o;
  logic [4:0]      apu_flags_o;
  logic            core_ready_i;

  modport master (output apu_rvalid_o, output apu_result_o, output apu_flags_o,
                  input core_ready_i);
  modport slave  (input apu_rvalid_o, input apu_result_o, input apu_flags_o,
                  output core_ready_i);
endinterface

// File: rtl/apu_result_queue_sync_fifo.sv
// Synchronous FIFO storage with wrapping pointers and a registered full flag.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic [CW-1:0]    w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset; the top masks the head output while empty.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;

endmodule

// File: rtl/apu_result_queue.sv
// Formats scalar APU results (VL, vtype, vs2 element) to ELEN and queues them in order.
// Optional per-entry flags are enabled by defining APU_RESULT_FLAGS_EN.
module apu_result_queue
  import apu_result_queue_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int ELEN  = 32,
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(VLEN/8)
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   res_valid_i,
  input  apu_result_src_t        res_src_i,
  input  logic                   res_signed_i,
  input  logic [IDX_W-1:0]       elem_idx_i,
  input  logic [4:0]             vl_next_i,
  input  logic [4:0]             vtype_i,
  input  logic [1:0]             vsew_i,
  input  logic [VLEN-1:0]        vs2_data_i,
  input  logic                   sat_flag_i,
  apu_result_queue_if.master     rsp,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);
`ifdef APU_RESULT_FLAGS_EN
  localparam int ENTRY_W = ELEN + APU_FLAGS_W;
`else
  localparam int ENTRY_W = ELEN;
`endif

  localparam logic [IDX_W:0] NE8  = (IDX_W+1)'(VLEN / 8);
  localparam logic [IDX_W:0] NE16 = (IDX_W+1)'(VLEN / 16);
  localparam logic [IDX_W:0] NE32 = (IDX_W+1)'(VLEN / 32);

  logic [IDX_W+4:0]   w_bit_off;
  logic [31:0]        w_elem_raw;
  logic [ELEN-1:0]    w_elem_ext;
  logic               w_invalid;
  logic [ELEN-1:0]    w_data;
  logic               w_push;
  logic               w_pop;
  logic               w_rvalid;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic               r_overflow;

  always_comb begin
    w_bit_off = '0;
    w_invalid = 1'b0;
    case (vsew_i)
      2'd0: begin
        w_bit_off = {2'b00, elem_idx_i, 3'b000};
        w_invalid = ({1'b0, elem_idx_i} >= NE8);
      end
      2'd1: begin
        w_bit_off = {1'b0, elem_idx_i, 4'b0000};
        w_invalid = ({1'b0, elem_idx_i} >= NE16);
      end
      2'd2: begin
        w_bit_off = {elem_idx_i, 5'b00000};
        w_invalid = ({1'b0, elem_idx_i} >= NE32);
      end
      default: begin
        w_bit_off = '0;
        w_invalid = 1'b1;
      end
    endcase
  end

  assign w_elem_raw = 32'(vs2_data_i >> w_bit_off);

  always_comb begin
    w_elem_ext = '0;
    case (vsew_i)
      2'd0:    w_elem_ext = res_signed_i ? ELEN'($signed(w_elem_raw[7:0]))
                                         : ELEN'(w_elem_raw[7:0]);
      2'd1:    w_elem_ext = res_signed_i ? ELEN'($signed(w_elem_raw[15:0]))
                                         : ELEN'(w_elem_raw[15:0]);
      default: w_elem_ext = res_signed_i ? ELEN'($signed(w_elem_raw))
                                         : ELEN'(w_elem_raw);
    endcase
  end

  always_comb begin
    w_data = '0;
    case (res_src_i)
      APU_SRC_VL:       w_data = ELEN'(vl_next_i);
      APU_SRC_VTYPE:    w_data = ELEN'(vtype_i);
      APU_SRC_VS2_ELEM: w_data = w_invalid ? '0 : w_elem_ext;
      default:          w_data = '0;
    endcase
  end

  assign w_rvalid = (count_o != '0);
  assign w_pop    = w_rvalid & rsp.core_ready_i;
  assign w_push   = res_valid_i & (~full_o | w_pop);

`ifdef APU_RESULT_FLAGS_EN
  logic [APU_FLAGS_W-1:0] w_flags;
  always_comb begin
    w_flags = '0;
    w_flags[APU_FLAG_INVALID_IDX] = (res_src_i == APU_SRC_VS2_ELEM) & w_invalid;
    w_flags[APU_FLAG_SAT]         = sat_flag_i;
  end
  assign w_wdata         = {w_flags, w_data};
  assign rsp.apu_flags_o = w_rvalid ? w_rdata[ENTRY_W-1:ELEN] : '0;
`else
  logic w_unused_sat;
  assign w_unused_sat    = sat_flag_i;
  assign w_wdata         = w_data;
  assign rsp.apu_flags_o = '0;
`endif

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (n_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (count_o),
    .o_full  (full_o)
  );

  // Sticky until reset: a result was lost because the queue was full.
  always_ff @(posedge clk) begin
    if (n_reset) r_overflow <= 1'b0;
    else if (res_valid_i & full_o & ~w_pop) r_overflow <= 1'b1;
  end

  assign overflow_o       = r_overflow;
  assign rsp.apu_rvalid_o = w_rvalid;
  assign rsp.apu_result_o = w_rvalid ? w_rdata[ELEN-1:0] : '0;

endmodule

// File: tb/tb_apu_result_queue.sv
// Scoreboard bench for apu_result_queue: directed pushes queue expected results,
// a negedge monitor compares every popped head entry.
module tb_apu_result_queue;
  import apu_result_queue_pkg::*;

`ifdef APU_RESULT_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            n_reset = 1'b1;
  logic            res_valid_i = 1'b0;
  apu_result_src_t res_src_i = APU_SRC_VL;
  logic            res_signed_i = 1'b0;
  logic [3:0]      elem_idx_i = '0;
  logic [4:0]      vl_next_i = '0;
  logic [4:0]      vtype_i = '0;
  logic [1:0]      vsew_i = '0;
  logic [127:0]    vs2_data_i = '0;
  logic            sat_flag_i = 1'b0;
  logic            full_o;
  logic [2:0]      count_o;
  logic            overflow_o;

  apu_result_queue_if #(.ELEN(32)) rsp ();

  apu_result_queue #(.VLEN(128), .ELEN(32), .DEPTH(4)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .res_valid_i  (res_valid_i),
    .res_src_i    (res_src_i),
    .res_signed_i (res_signed_i),
    .elem_idx_i   (elem_idx_i),
    .vl_next_i    (vl_next_i),
    .vtype_i      (vtype_i),
    .vsew_i       (vsew_i),
    .vs2_data_i   (vs2_data_i),
    .sat_flag_i   (sat_flag_i),
    .rsp          (rsp),
    .full_o       (full_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a head entry that is valid while ready is high pops at the next edge.
  always @(negedge clk) begin
    if (!n_reset && rsp.apu_rvalid_o && rsp.core_ready_i) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", {27'd0, rsp.apu_flags_o, rsp.apu_result_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("pop", {27'd0, rsp.apu_flags_o, rsp.apu_result_o}, {27'd0, e});
      end
    end
  end

  task automatic do_push(input apu_result_src_t src, input logic sgn, input logic [3:0] idx,
                         input logic [1:0] sew, input logic [4:0] vl, input logic [4:0] vt,
                         input logic sat, input logic [31:0] exp_res, input logic [4:0] exp_fl,
                         input bit accept);
    res_src_i = src; res_signed_i = sgn; elem_idx_i = idx; vsew_i = sew;
    vl_next_i = vl; vtype_i = vt; sat_flag_i = sat; res_valid_i = 1'b1;
    if (accept) sb.push_back({(FLAGS_EN ? exp_fl : 5'd0), exp_res});
    @(posedge clk); #1;
    res_valid_i = 1'b0; sat_flag_i = 1'b0;
  endtask

  task automatic do_reset();
    n_reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    n_reset = 1'b0;
  endtask

  initial begin
    rsp.core_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b0;
    chk("rst_rvalid", 64'(rsp.apu_rvalid_o), 64'd0);
    chk("rst_result", 64'(rsp.apu_result_o), 64'd0);
    chk("rst_flags", 64'(rsp.apu_flags_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);

    // VL push, one-cycle latency, then pop
    do_push(APU_SRC_VL, 0, 4'd0, 2'd0, 5'd16, 5'd0, 0, 32'h0000_0010, 5'd0, 1);
    chk("vl_rvalid", 64'(rsp.apu_rvalid_o), 64'd1);
    chk("vl_count", 64'(count_o), 64'd1);
    rsp.core_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("vl_count_after_pop", 64'(count_o), 64'd0);
    chk("vl_rvalid_after_pop", 64'(rsp.apu_rvalid_o), 64'd0);

    // Element extraction and extension, core always ready
    vs2_data_i = 128'hDEADBEEF_00000000_00008001_85000000;
    do_push(APU_SRC_VS2_ELEM, 1, 4'd3, 2'd0, 5'd0, 5'd0, 0, 32'hFFFF_FF85, 5'd0, 1);
    do_push(APU_SRC_VS2_ELEM, 0, 4'd3, 2'd0, 5'd0, 5'd0, 0, 32'h0000_0085, 5'd0, 1);
    do_push(APU_SRC_VS2_ELEM, 1, 4'd2, 2'd1, 5'd0, 5'd0, 0, 32'hFFFF_8001, 5'd0, 1);
    do_push(APU_SRC_VS2_ELEM, 0, 4'd3, 2'd2, 5'd0, 5'd0, 1, 32'hDEAD_BEEF, 5'b00010, 1);
    do_push(APU_SRC_VTYPE, 0, 4'd0, 2'd0, 5'd0, 5'h13, 0, 32'h0000_0013, 5'd0, 1);
    // Out-of-range index and reserved SEW
    do_push(APU_SRC_VS2_ELEM, 1, 4'd8, 2'd1, 5'd0, 5'd0, 0, 32'h0, 5'b00001, 1);
    do_push(APU_SRC_VS2_ELEM, 0, 4'd0, 2'd3, 5'd0, 5'd0, 1, 32'h0, 5'b00011, 1);
    repeat (2) @(posedge clk); #1;
    chk("drain1_count", 64'(count_o), 64'd0);
    chk("drain1_sb", 64'(sb.size()), 64'd0);

    // Fill to full with the core stalled, fifth push dropped
    rsp.core_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++)
      do_push(APU_SRC_VL, 0, 4'd0, 2'd0, 5'(i), 5'd0, 0, 32'(i), 5'd0, 1);
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_count", 64'(count_o), 64'd4);
    chk("fill_ovf_before", 64'(overflow_o), 64'd0);
    do_push(APU_SRC_VL, 0, 4'd0, 2'd0, 5'd5, 5'd0, 0, 32'd5, 5'd0, 0);
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk("ovf_count", 64'(count_o), 64'd4);
    rsp.core_ready_i = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("drain2_count", 64'(count_o), 64'd0);
    chk("drain2_full", 64'(full_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    chk("drain2_sb", 64'(sb.size()), 64'd0);
    rsp.core_ready_i = 1'b0;
    do_reset();
    chk("ovf_cleared", 64'(overflow_o), 64'd0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++)
      do_push(APU_SRC_VTYPE, 0, 4'd0, 2'd0, 5'd0, 5'(10 + i), 0, 32'(10 + i), 5'd0, 1);
    chk("pp_full_before", 64'(full_o), 64'd1);
    rsp.core_ready_i = 1'b1;
    do_push(APU_SRC_VL, 0, 4'd0, 2'd0, 5'h1F, 5'd0, 0, 32'h1F, 5'd0, 1);
    rsp.core_ready_i = 1'b0;
    chk("pp_count", 64'(count_o), 64'd4);
    chk("pp_full", 64'(full_o), 64'd1);
    chk("pp_ovf", 64'(overflow_o), 64'd0);
    rsp.core_ready_i = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("drain3_sb", 64'(sb.size()), 64'd0);
    chk("drain3_count", 64'(count_o), 64'd0);
    rsp.core_ready_i = 1'b0;

    // Reset discards queued entries
    for (int i = 0; i < 3; i++)
      do_push(APU_SRC_VL, 0, 4'd0, 2'd0, 5'(20 + i), 5'd0, 0, 32'(20 + i), 5'd0, 1);
    chk("pre_rst_count", 64'(count_o), 64'd3);
    do_reset();
    chk("mid_rst_rvalid", 64'(rsp.apu_rvalid_o), 64'd0);
    chk("mid_rst_count", 64'(count_o), 64'd0);
    chk("mid_rst_full", 64'(full_o), 64'd0);
    chk("mid_rst_result", 64'(rsp.apu_result_o), 64'd0);

    repeat (2) @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
